vga_timing_detector: RTL and testbench

- Receive-side counterpart of the VGA timing generator.
- Samples hsync/vsync, measures line length and frame height, and locks onto a stable mode.
- Regenerates column/row counters and an active-video flag, phase-aligned to the source.
- Sits at the input of capture/overlay logic in the same i_clk domain as the timing source.

---
 rtl/vga_timing_detector_if.sv | 30 +++
 rtl/vga_timing_detector.sv | 198 +++++++++++++++++++
 tb/tb_vga_timing_detector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_detector_if.sv
// Sync-in / timing-out bundle of the VGA timing detector.
// Latency: none (pure wiring).
// Backpressure: none; the sync source runs freely every i_clk cycle.
// master: sync source side (drives i_hsync/i_vsync, observes the results).
// slave : detector side (samples syncs, drives the lock/counter/measurement outputs).
interface vga_timing_detector_if #(
    parameter int CNT_W = 11
) ();
    logic             i_hsync;
    logic             i_vsync;
    logic             o_locked;
    logic [CNT_W-1:0] o_col_count;
    logic [CNT_W-1:0] o_row_count;
    logic             o_de;
    logic [CNT_W-1:0] o_line_len;
    logic [CNT_W-1:0] o_frame_lines;
    logic             o_timeout;

    modport master (
        output i_hsync, i_vsync,
        input  o_locked, o_col_count, o_row_count, o_de,
        input  o_line_len, o_frame_lines, o_timeout
    );

    modport slave (
        input  i_hsync, i_vsync,
        output o_locked, o_col_count, o_row_count, o_de,
        output o_line_len, o_frame_lines, o_timeout
    );
endinterface

// File: rtl/vga_timing_detector.sv
// Locks onto an incoming hsync/vsync pair and regenerates column/row counters and active video.
// Latency: counters lag the source by one cycle; o_de is aligned with o_col_count/o_row_count.
// Backpressure: none; every cycle is consumed, loss of hsync is flagged by o_timeout.
// Ports: i_clk, i_reset (sync, active-high), vif.slave (i_hsync/i_vsync in; o_locked,
//   o_col_count, o_row_count, o_de, o_line_len, o_frame_lines, o_timeout out).
// Optional: define VGA_SYNC_POL_DETECT_EN to auto-detect sync polarity while searching.
module vga_timing_detector #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int CNT_W       = 11,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    vga_timing_detector_if.slave  vif
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] ACOLS      = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] AROWS      = CNT_W'(ACTIVE_ROWS);
    localparam logic [3:0]       LOCK_N     = 4'(LOCK_FRAMES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic             hs_q, vs_q;          // raw (pre-polarity) sync history
    logic             hs_inv, vs_inv, pol_done;
    logic             hs_fe, vs_fe;
    logic [CNT_W-1:0] col, row, col_nxt, row_nxt;
    logic [CNT_W-1:0] line_len, frame_lines, len_meas, lines_meas;
    logic             hs_seen, vs_seen;    // a reference edge exists since reset/SEARCH entry
    logic             ll_vld, fl_vld;      // line_len/frame_lines hold a fresh measurement
    logic [3:0]       match_cnt;
    logic             locked, de, timeout;
    logic             line_bad, frame_bad, to_hit;

    // Polarity is applied to both history and live input so a polarity flip never fakes an edge.
    assign hs_fe = (hs_q ^ hs_inv) & ~(vif.i_hsync ^ hs_inv);
    assign vs_fe = (vs_q ^ vs_inv) & ~(vif.i_vsync ^ vs_inv);

    // At an hsync edge the counter still holds the last column of the previous line.
    assign len_meas   = col + 1'b1;
    assign lines_meas = row + 1'b1;
    assign line_bad   = hs_fe && hs_seen && ll_vld && (len_meas != line_len);
    assign frame_bad  = vs_fe && vs_seen && fl_vld && (lines_meas != frame_lines);
    // Fires on the cycle the column counter is about to reach all-ones, so only once per stall.
    assign to_hit     = !hs_fe && (col == CNT_MAX_M1);

    always_comb begin
        col_nxt = hs_fe ? '0 : sat_inc(col);
        row_nxt = row;
        if (vs_fe)
            row_nxt = '0;
        else if (hs_fe)
            row_nxt = sat_inc(row);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            col         <= '0;
            row         <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            hs_seen     <= 1'b0;
            vs_seen     <= 1'b0;
            ll_vld      <= 1'b0;
            fl_vld      <= 1'b0;
            match_cnt   <= '0;
            locked      <= 1'b0;
            de          <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            hs_q    <= vif.i_hsync;
            vs_q    <= vif.i_vsync;
            col     <= col_nxt;
            row     <= row_nxt;
            timeout <= to_hit;
            // Built from the next counter values so o_de lines up with o_col_count/o_row_count.
            de <= locked && (line_len >= ACOLS) && (frame_lines >= AROWS)
                  && (col_nxt >= line_len - ACOLS) && (row_nxt >= frame_lines - AROWS);

            if (hs_fe) begin
                hs_seen <= 1'b1;
                if (hs_seen) begin
                    line_len <= len_meas;
                    ll_vld   <= 1'b1;
                end
            end
            if (vs_fe) begin
                vs_seen <= 1'b1;
                if (vs_seen) begin
                    frame_lines <= lines_meas;
                    fl_vld      <= 1'b1;
                end
            end

            // Dropping to SEARCH discards every reference; these writes override the ones above.
            if (to_hit || (state == LOCKED && (line_bad || frame_bad))) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
                hs_seen   <= 1'b0;
                vs_seen   <= 1'b0;
                ll_vld    <= 1'b0;
                fl_vld    <= 1'b0;
            end else begin
                case (state)
                    SEARCH: begin
                        match_cnt <= '0;
                        if (vs_fe && pol_done)
                            state <= MEASURE;
                    end
                    MEASURE: begin
                        if (line_bad) begin
                            match_cnt <= '0;
                        end else if (vs_fe && vs_seen) begin
                            // First frame measurement only becomes the reference.
                            if (!fl_vld || frame_bad) begin
                                match_cnt <= '0;
                            end else if (match_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef VGA_SYNC_POL_DETECT_EN
    // Per sync: wait raw fall, count low time, count high time, decide at the next raw fall.
    // hsync is timed in cycles, vsync in lines (raw hsync rising edges, polarity-independent).
    logic [1:0]       hp_ph, vp_ph;
    logic [CNT_W-1:0] hp_lo, hp_hi, vp_lo, vp_hi;
    logic             hs_raw_fe, hs_raw_re, vs_raw_fe, vs_raw_re;

    assign hs_raw_fe = hs_q & ~vif.i_hsync;
    assign hs_raw_re = ~hs_q & vif.i_hsync;
    assign vs_raw_fe = vs_q & ~vif.i_vsync;
    assign vs_raw_re = ~vs_q & vif.i_vsync;
    assign pol_done  = (hp_ph == 2'd3) && (vp_ph == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hp_ph  <= 2'd0;
            vp_ph  <= 2'd0;
            hp_lo  <= '0;
            hp_hi  <= '0;
            vp_lo  <= '0;
            vp_hi  <= '0;
            hs_inv <= 1'b0;
            vs_inv <= 1'b0;
        end else if (state != SEARCH) begin
            // Polarity is held; measurement restarts on the next SEARCH entry.
            hp_ph <= 2'd0;
            vp_ph <= 2'd0;
        end else begin
            case (hp_ph)
                2'd0: if (hs_raw_fe) begin hp_ph <= 2'd1; hp_lo <= '0; hp_hi <= '0; end
                2'd1: if (hs_raw_re) hp_ph <= 2'd2; else hp_lo <= sat_inc(hp_lo);
                2'd2: if (hs_raw_fe) begin hp_ph <= 2'd3; hs_inv <= (hp_hi < hp_lo); end
                      else hp_hi <= sat_inc(hp_hi);
                default: ;
            endcase
            case (vp_ph)
                2'd0: if (vs_raw_fe) begin vp_ph <= 2'd1; vp_lo <= '0; vp_hi <= '0; end
                2'd1: if (vs_raw_re) vp_ph <= 2'd2;
                      else if (hs_raw_re) vp_lo <= sat_inc(vp_lo);
                2'd2: if (vs_raw_fe) begin vp_ph <= 2'd3; vs_inv <= (vp_hi < vp_lo); end
                      else if (hs_raw_re) vp_hi <= sat_inc(vp_hi);
                default: ;
            endcase
        end
    end
`else
    assign hs_inv   = 1'b0;
    assign vs_inv   = 1'b0;
    assign pol_done = 1'b1;
`endif

    assign vif.o_locked      = locked;
    assign vif.o_col_count   = col;
    assign vif.o_row_count   = row;
    assign vif.o_de          = de;
    assign vif.o_line_len    = line_len;
    assign vif.o_frame_lines = frame_lines;
    assign vif.o_timeout     = timeout;
endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector on a scaled-down mode (24x14 total, 16x8 active).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; the bench generator drives one pixel per clock.
module tb_vga_timing_detector;
    localparam int AC = 16, AR = 8;     // active cols/rows
    localparam int L  = 24, HS = 4;     // total cols, hsync width
    localparam int F  = 14, VS = 3;     // total rows, vsync width
    localparam int CW = 11, LF = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_detector_if #(.CNT_W(CW)) vif ();

    vga_timing_detector #(
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .CNT_W(CW), .LOCK_FRAMES(LF)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .vif     (vif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit pol_inv = 1'b0;

    // Per-frame statistics gathered by run_frame.
    int n_locked, n_unlocked, col_bad, row_bad, de_bad, de_cnt;
    int first_de_c, first_de_r, drop_c, drop_r, to_cnt;
    logic [46:0] rst_snap;

    // Drive one source pixel (c,r); afterwards the outputs reflect that pixel.
    task automatic drive_cycle(input int c, input int r, input bit rs);
        rst = rs;
        vif.i_hsync = pol_inv ^ (c >= HS);
        vif.i_vsync = pol_inv ^ (r >= VS);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int stretch_row, input int rst_row);
        bit   was_locked;
        logic exp_de;
        n_locked = 0; n_unlocked = 0; col_bad = 0; row_bad = 0; de_bad = 0; de_cnt = 0;
        first_de_c = -1; first_de_r = -1; drop_c = -1; drop_r = -1; to_cnt = 0;
        was_locked = vif.o_locked;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < ((r == stretch_row) ? L + 1 : L); c++) begin
                drive_cycle(c, r, (r == rst_row) && (c == 0));
                if (r == rst_row && c == 0)
                    rst_snap = {vif.o_locked, vif.o_de, vif.o_timeout, vif.o_col_count,
                                vif.o_row_count, vif.o_line_len, vif.o_frame_lines};
                if (vif.o_locked === 1'b1) n_locked++; else n_unlocked++;
                if (was_locked && vif.o_locked !== 1'b1 && drop_c < 0) begin
                    drop_c = c; drop_r = r;
                end
                was_locked = (vif.o_locked === 1'b1);
                if (vif.o_col_count !== CW'(c)) col_bad++;
                if (vif.o_row_count !== CW'(r)) row_bad++;
                exp_de = (c >= L - AC) && (r >= F - AR);
                if (vif.o_de !== exp_de) de_bad++;
                if (vif.o_de === 1'b1) begin
                    de_cnt++;
                    if (first_de_c < 0) begin first_de_c = c; first_de_r = r; end
                end
                if (vif.o_timeout === 1'b1) to_cnt++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vif.i_hsync = 1'b1; vif.i_vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (vif.o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", vif.o_locked); end
        n_tests++; if (vif.o_col_count !== 11'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", vif.o_col_count); end
        n_tests++; if (vif.o_row_count !== 11'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", vif.o_row_count); end
        n_tests++; if (vif.o_de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", vif.o_de); end
        n_tests++; if (vif.o_line_len !== 11'd0) begin n_fail++; $display("FAIL reset_line_len: got %0d want 0", vif.o_line_len); end
        n_tests++; if (vif.o_frame_lines !== 11'd0) begin n_fail++; $display("FAIL reset_frame_lines: got %0d want 0", vif.o_frame_lines); end
        n_tests++; if (vif.o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", vif.o_timeout); end
    endtask

    task automatic test_acquire();
        int lk;
        run_frame(-1, -1);
        lk = n_locked;
        run_frame(-1, -1);
        lk += n_locked;
        n_tests++; if (vif.o_line_len !== CW'(L)) begin n_fail++; $display("FAIL acq_line_len: got %0d want %0d", vif.o_line_len, L); end
        n_tests++; if (vif.o_frame_lines !== CW'(F)) begin n_fail++; $display("FAIL acq_frame_lines: got %0d want %0d", vif.o_frame_lines, F); end
        run_frame(-1, -1);
        lk += n_locked;
        n_tests++; if (lk !== 0) begin n_fail++; $display("FAIL acq_early_lock: locked cycles %0d want 0", lk); end
        run_frame(-1, -1);
        n_tests++; if (n_unlocked !== 0) begin n_fail++; $display("FAIL acq_frame4_lock: unlocked cycles %0d want 0", n_unlocked); end
        n_tests++; if (col_bad !== 0) begin n_fail++; $display("FAIL acq_col_lag: mismatching cycles %0d want 0", col_bad); end
        n_tests++; if (row_bad !== 0) begin n_fail++; $display("FAIL acq_row_lag: mismatching cycles %0d want 0", row_bad); end
    endtask

    task automatic test_de();
        run_frame(-1, -1);
        n_tests++; if (de_cnt !== AC * AR) begin n_fail++; $display("FAIL de_count: got %0d want %0d", de_cnt, AC * AR); end
        n_tests++; if (first_de_c !== L - AC || first_de_r !== F - AR) begin
            n_fail++; $display("FAIL de_first: got col %0d row %0d want col %0d row %0d", first_de_c, first_de_r, L - AC, F - AR);
        end
        n_tests++; if (de_bad !== 0) begin n_fail++; $display("FAIL de_shape: mismatching cycles %0d want 0", de_bad); end
    endtask

    task automatic test_stretch();
        int lk;
        run_frame(5, -1);
        n_tests++; if (drop_c !== 0 || drop_r !== 6) begin
            n_fail++; $display("FAIL stretch_drop: dropped at col %0d row %0d want col 0 row 6", drop_c, drop_r);
        end
        lk = 0;
        for (int i = 0; i < 3; i++) begin
            run_frame(-1, -1);
            lk += n_locked;
        end
        n_tests++; if (lk !== 0) begin n_fail++; $display("FAIL stretch_early_relock: locked cycles %0d want 0", lk); end
        run_frame(-1, -1);
        n_tests++; if (n_unlocked !== 0) begin n_fail++; $display("FAIL stretch_relock: unlocked cycles %0d want 0", n_unlocked); end
        n_tests++; if (vif.o_line_len !== CW'(L)) begin n_fail++; $display("FAIL stretch_line_len: got %0d want %0d", vif.o_line_len, L); end
    endtask

    task automatic test_timeout();
        int pulses, pulse_at, lk, tos;
        logic lock_at_pulse;
        pulses = 0; pulse_at = -1; lock_at_pulse = 1'bx;
        for (int i = 1; i <= 2047; i++) begin
            drive_cycle(L - 1, F - 1, 1'b0);
            if (vif.o_timeout === 1'b1) begin
                pulses++;
                if (pulse_at < 0) begin pulse_at = i; lock_at_pulse = vif.o_locked; end
            end
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        n_tests++; if (pulse_at !== 2024) begin n_fail++; $display("FAIL timeout_when: got cycle %0d want 2024", pulse_at); end
        n_tests++; if (lock_at_pulse !== 1'b0) begin n_fail++; $display("FAIL timeout_unlock: got %b want 0", lock_at_pulse); end
        lk = 0; tos = 0;
        for (int i = 0; i < 3; i++) begin
            run_frame(-1, -1);
            lk += n_locked; tos += to_cnt;
        end
        n_tests++; if (lk !== 0) begin n_fail++; $display("FAIL timeout_search: locked cycles %0d want 0", lk); end
        n_tests++; if (tos !== 0) begin n_fail++; $display("FAIL timeout_repeat: extra pulses %0d want 0", tos); end
        run_frame(-1, -1);
        n_tests++; if (n_unlocked !== 0) begin n_fail++; $display("FAIL timeout_relock: unlocked cycles %0d want 0", n_unlocked); end
    endtask

    task automatic test_reset_midframe();
        int lk;
        run_frame(-1, 10);
        n_tests++; if (rst_snap !== 47'd0) begin n_fail++; $display("FAIL midrst_outputs: got %h want 0", rst_snap); end
        lk = 0;
        for (int i = 0; i < LF + 1; i++) begin
            run_frame(-1, -1);
            lk += n_locked;
        end
        n_tests++; if (lk !== 0) begin n_fail++; $display("FAIL midrst_early_lock: locked cycles %0d want 0", lk); end
        run_frame(-1, -1);
        n_tests++; if (n_unlocked !== 0) begin n_fail++; $display("FAIL midrst_relock: unlocked cycles %0d want 0", n_unlocked); end
        n_tests++; if (col_bad !== 0) begin n_fail++; $display("FAIL midrst_col: mismatching cycles %0d want 0", col_bad); end
    endtask

`ifdef VGA_SYNC_POL_DETECT_EN
    task automatic test_pol_detect();
        pol_inv = 1'b1;
        rst = 1'b1; vif.i_hsync = 1'b0; vif.i_vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) run_frame(-1, -1);
        n_tests++; if (n_unlocked !== 0) begin n_fail++; $display("FAIL pol_lock: unlocked cycles %0d want 0", n_unlocked); end
        n_tests++; if (col_bad !== 0) begin n_fail++; $display("FAIL pol_col: mismatching cycles %0d want 0", col_bad); end
        n_tests++; if (vif.o_line_len !== CW'(L)) begin n_fail++; $display("FAIL pol_line_len: got %0d want %0d", vif.o_line_len, L); end
        n_tests++; if (vif.o_frame_lines !== CW'(F)) begin n_fail++; $display("FAIL pol_frame_lines: got %0d want %0d", vif.o_frame_lines, F); end
        pol_inv = 1'b0;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        vif.i_hsync = 1'b1;
        vif.i_vsync = 1'b1;
        test_reset();
`ifdef VGA_SYNC_POL_DETECT_EN
        test_pol_detect();
`else
        test_acquire();
        test_de();
        test_stretch();
        test_timeout();
        test_reset_midframe();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
